// File: rtl/fm_axi_req_arbiter.sv
// Two-client round-robin arbiter that turns single-word register requests
// into single-beat AXI4 write (AW/W/B) or read (AR/R) transactions.
// One transaction is in flight at a time. Each response goes back only to
// the client that issued the request.
module fm_axi_req_arbiter #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_ID_BIT_COUNT = 6
) (
  input  logic                        clk_axi,
  input  logic                        reset_axi_n,
  // client 0
  input  logic                        req0_valid,
  input  logic                        req0_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [31:0]                 req0_wdata,
  output logic                        req0_ready,
  output logic                        rsp0_valid,
  output logic [31:0]                 rsp0_rdata,
  output logic [1:0]                  rsp0_resp,
  // client 1
  input  logic                        req1_valid,
  input  logic                        req1_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [31:0]                 req1_wdata,
  output logic                        req1_ready,
  output logic                        rsp1_valid,
  output logic [31:0]                 rsp1_rdata,
  output logic [1:0]                  rsp1_resp,
  // AXI write channels
  output logic [AXI_ID_BIT_COUNT-1:0] m_writeMOSI_id,
  output logic [AXI_ADDR_WIDTH-1:0]   m_writeMOSI_address,
  output logic                        m_writeMOSI_address_valid,
  output logic [7:0]                  m_writeMOSI_burst_length,
  output logic [2:0]                  m_writeMOSI_burst_size,
  output logic [1:0]                  m_writeMOSI_burst_type,
  output logic                        m_writeMOSI_lock,
  output logic [3:0]                  m_writeMOSI_cache,
  output logic [3:0]                  m_writeMOSI_qos,
  output logic [3:0]                  m_writeMOSI_region,
  output logic                        m_writeMOSI_user,
  output logic [2:0]                  m_writeMOSI_prot,
  output logic [31:0]                 m_writeMOSI_data,
  output logic                        m_writeMOSI_data_valid,
  output logic [3:0]                  m_writeMOSI_data_write_strobe,
  output logic                        m_writeMOSI_last,
  output logic                        m_writeMOSI_ready_for_response,
  input  logic                        m_writeMISO_ready_for_address,
  input  logic                        m_writeMISO_ready_for_data,
  input  logic                        m_writeMISO_response_valid,
  input  logic [1:0]                  m_writeMISO_response,
  // AXI read channels
  output logic [AXI_ID_BIT_COUNT-1:0] m_readMOSI_id,
  output logic [AXI_ADDR_WIDTH-1:0]   m_readMOSI_address,
  output logic                        m_readMOSI_address_valid,
  output logic [7:0]                  m_readMOSI_burst_length,
  output logic [2:0]                  m_readMOSI_burst_size,
  output logic [1:0]                  m_readMOSI_burst_type,
  output logic                        m_readMOSI_lock,
  output logic [3:0]                  m_readMOSI_cache,
  output logic [3:0]                  m_readMOSI_qos,
  output logic [3:0]                  m_readMOSI_region,
  output logic                        m_readMOSI_user,
  output logic [2:0]                  m_readMOSI_prot,
  output logic                        m_readMOSI_ready_for_data,
  input  logic                        m_readMISO_ready_for_address,
  input  logic [31:0]                 m_readMISO_data,
  input  logic                        m_readMISO_data_valid,
  input  logic [1:0]                  m_readMISO_response
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t                      state, state_nxt;
  logic                        last_grant, grant_any, grant_idx;
  logic                        sel_write;
  logic [AXI_ADDR_WIDTH-1:0]   sel_addr;
  logic [31:0]                 sel_wdata;
  logic                        cap_write, cap_owner, aw_pend, w_pend;
  logic [AXI_ADDR_WIDTH-1:0]   cap_addr;
  logic [31:0]                 cap_wdata, cap_rdata;
  logic [1:0]                  cap_resp;
  logic                        aw_hs, w_hs;

  // Arbitration: a lone requester wins; on a tie the client not granted last wins.
  always_comb begin
    grant_any = (state == IDLE) && (req0_valid || req1_valid);
    grant_idx = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_write = grant_idx ? req1_write : req0_write;
    sel_addr  = grant_idx ? req1_addr  : req0_addr;
    sel_wdata = grant_idx ? req1_wdata : req0_wdata;
  end

  assign req0_ready = grant_any && !grant_idx;
  assign req1_ready = grant_any &&  grant_idx;

  // AW and W are tracked separately so each drops after its own handshake.
  assign m_writeMOSI_address_valid = (state == WR_ADDR) && aw_pend;
  assign m_writeMOSI_data_valid    = (state == WR_ADDR) && w_pend;
  assign aw_hs = m_writeMOSI_address_valid && m_writeMISO_ready_for_address;
  assign w_hs  = m_writeMOSI_data_valid    && m_writeMISO_ready_for_data;

  assign m_writeMOSI_ready_for_response = (state == WR_RESP);
  assign m_readMOSI_address_valid       = (state == RD_ADDR);
  assign m_readMOSI_ready_for_data      = (state == RD_DATA);
  assign m_writeMOSI_address            = cap_addr;
  assign m_readMOSI_address             = cap_addr;
  assign m_writeMOSI_data               = cap_wdata;

  // Response pulse is steered to the owner only; payload is zero otherwise.
  assign rsp0_valid = (state == RESP) && !cap_owner;
  assign rsp1_valid = (state == RESP) &&  cap_owner;
  assign rsp0_rdata = rsp0_valid ? cap_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? cap_rdata : '0;
  assign rsp0_resp  = rsp0_valid ? cap_resp  : '0;
  assign rsp1_resp  = rsp1_valid ? cap_resp  : '0;

  // Fixed single-beat, 32-bit, INCR transaction attributes.
  assign m_writeMOSI_id                = '0;
  assign m_writeMOSI_burst_length      = 8'd0;
  assign m_writeMOSI_burst_size        = 3'b010;
  assign m_writeMOSI_burst_type        = 2'b01;
  assign m_writeMOSI_lock              = 1'b0;
  assign m_writeMOSI_cache             = 4'd0;
  assign m_writeMOSI_qos               = 4'd0;
  assign m_writeMOSI_region            = 4'd0;
  assign m_writeMOSI_user              = 1'b0;
  assign m_writeMOSI_prot              = 3'd0;
  assign m_writeMOSI_data_write_strobe = 4'hF;
  assign m_writeMOSI_last              = 1'b1;
  assign m_readMOSI_id                 = '0;
  assign m_readMOSI_burst_length       = 8'd0;
  assign m_readMOSI_burst_size         = 3'b010;
  assign m_readMOSI_burst_type         = 2'b01;
  assign m_readMOSI_lock               = 1'b0;
  assign m_readMOSI_cache              = 4'd0;
  assign m_readMOSI_qos                = 4'd0;
  assign m_readMOSI_region             = 4'd0;
  assign m_readMOSI_user               = 1'b0;
  assign m_readMOSI_prot               = 3'd0;

  // Next-state: one transaction at a time, always passing through RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = sel_write ? WR_ADDR : RD_ADDR;
      WR_ADDR: if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (m_writeMISO_response_valid) state_nxt = RESP;
      RD_ADDR: if (m_readMISO_ready_for_address) state_nxt = RD_DATA;
      RD_DATA: if (m_readMISO_data_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_axi or negedge reset_axi_n) begin
    if (!reset_axi_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Request capture, channel-pending flags and response capture.
  always_ff @(posedge clk_axi or negedge reset_axi_n) begin
    if (!reset_axi_n) begin
      last_grant <= 1'b1;
      cap_owner  <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_rdata  <= '0;
      cap_resp   <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
        cap_owner  <= grant_idx;
        cap_write  <= sel_write;
        cap_addr   <= sel_addr;
        cap_wdata  <= sel_wdata;
        cap_rdata  <= '0;
        cap_resp   <= '0;
        aw_pend    <= sel_write;
        w_pend     <= sel_write;
      end
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if ((state == WR_RESP) && m_writeMISO_response_valid)
        cap_resp <= m_writeMISO_response;
      if ((state == RD_DATA) && m_readMISO_data_valid) begin
        cap_rdata <= m_readMISO_data;
        cap_resp  <= m_readMISO_response;
      end
    end
  end

endmodule

// File: tb/tb_fm_axi_req_arbiter.sv
// Bench for fm_axi_req_arbiter: two client drivers and a slave model share a
// per-cycle step; expected responses are queued at acceptance and popped by
// an independent response monitor.
module tb_fm_axi_req_arbiter;
  localparam int AW  = 32;
  localparam int IDW = 6;

  logic clk_axi = 1'b0;
  logic reset_axi_n = 1'b0;
  always #5 clk_axi = ~clk_axi;

  logic          req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [31:0]   req0_wdata, rsp0_rdata;
  logic [1:0]    rsp0_resp;
  logic          req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [31:0]   req1_wdata, rsp1_rdata;
  logic [1:0]    rsp1_resp;
  logic [IDW-1:0] w_id, r_id;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [7:0]    w_len, r_len;
  logic [2:0]    w_size, r_size, w_prot, r_prot;
  logic [1:0]    w_burst, r_burst;
  logic          w_lock, r_lock, w_user, r_user;
  logic [3:0]    w_cache, r_cache, w_qos, r_qos, w_region, r_region, wstrb;
  logic [31:0]   wdata;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  fm_axi_req_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_ID_BIT_COUNT(IDW)) dut (
    .clk_axi(clk_axi), .reset_axi_n(reset_axi_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_resp(rsp0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_resp(rsp1_resp),
    .m_writeMOSI_id(w_id), .m_writeMOSI_address(awaddr),
    .m_writeMOSI_address_valid(awvalid), .m_writeMOSI_burst_length(w_len),
    .m_writeMOSI_burst_size(w_size), .m_writeMOSI_burst_type(w_burst),
    .m_writeMOSI_lock(w_lock), .m_writeMOSI_cache(w_cache), .m_writeMOSI_qos(w_qos),
    .m_writeMOSI_region(w_region), .m_writeMOSI_user(w_user), .m_writeMOSI_prot(w_prot),
    .m_writeMOSI_data(wdata), .m_writeMOSI_data_valid(wvalid),
    .m_writeMOSI_data_write_strobe(wstrb), .m_writeMOSI_last(wlast),
    .m_writeMOSI_ready_for_response(bready),
    .m_writeMISO_ready_for_address(awready), .m_writeMISO_ready_for_data(wready),
    .m_writeMISO_response_valid(bvalid), .m_writeMISO_response(bresp),
    .m_readMOSI_id(r_id), .m_readMOSI_address(araddr),
    .m_readMOSI_address_valid(arvalid), .m_readMOSI_burst_length(r_len),
    .m_readMOSI_burst_size(r_size), .m_readMOSI_burst_type(r_burst),
    .m_readMOSI_lock(r_lock), .m_readMOSI_cache(r_cache), .m_readMOSI_qos(r_qos),
    .m_readMOSI_region(r_region), .m_readMOSI_user(r_user), .m_readMOSI_prot(r_prot),
    .m_readMOSI_ready_for_data(rready),
    .m_readMISO_ready_for_address(arready), .m_readMISO_data(rdata),
    .m_readMISO_data_valid(rvalid), .m_readMISO_response(rresp)
  );

  typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } rsp_t;

  int n_chk = 0, n_pass = 0;
  rsp_t exp_q0[$], exp_q1[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  // client requests waiting to be accepted
  bit pend_v[2], pend_w[2];
  logic [31:0] pend_a[2], pend_d[2];
  int n_txn[2];
  // transaction in flight, as seen from the spec's rules
  bit busy, cur_write, cur_owner, last, b_done, r_done;
  logic [31:0] cur_addr, cur_wdata, slv_awaddr, slv_wdata, slv_araddr;
  int aw_cnt, w_cnt, ar_cnt, ar_hi;
  // knobs
  bit gen_en, req_always, rdy_all, hold_r;
  int ar_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[9:8];
  endfunction

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_pat(a);
  endfunction

  // One clock: drive clients and slave at negedge, then sample and check.
  task automatic step();
    logic [6:0] exp_v, act_v;
    logic [1:0] want, rdy, exp_r;
    bit rsp_now, w;
    rsp_t e;
    @(negedge clk_axi);
    for (int n = 0; n < 2; n++) begin
      if (pend_v[n] && gen_en && !req_always && $urandom_range(0, 19) == 0)
        pend_v[n] = 1'b0;
      else if (!pend_v[n] && gen_en && (req_always || $urandom_range(0, 2) == 0)) begin
        pend_v[n] = 1'b1;
        pend_w[n] = 1'($urandom_range(0, 1));
        pend_a[n] = rand_addr();
        pend_d[n] = $urandom;
      end
    end
    req0_valid = pend_v[0]; req0_write = pend_w[0]; req0_addr = pend_a[0]; req0_wdata = pend_d[0];
    req1_valid = pend_v[1]; req1_write = pend_w[1]; req1_addr = pend_a[1]; req1_wdata = pend_d[1];
    awready = rdy_all ? 1'b1 : 1'($urandom_range(0, 1));
    wready  = rdy_all ? 1'b1 : 1'($urandom_range(0, 1));
    if (ar_wait > 0) begin arready = 1'b0; ar_wait--; end
    else arready = rdy_all ? 1'b1 : 1'($urandom_range(0, 1));
    if (aw_cnt == 1 && w_cnt == 1 && !b_done) begin
      bvalid = rdy_all ? 1'b1 : 1'($urandom_range(0, 1));
      bresp  = resp_of(slv_awaddr);
    end else begin
      bvalid = ($urandom_range(0, 3) == 0);
      bresp  = 2'($urandom);
    end
    if (ar_cnt == 1 && !r_done) begin
      rvalid = !hold_r && (rdy_all || $urandom_range(0, 1) == 1);
      rdata  = slv_rd(slv_araddr);
      rresp  = resp_of(slv_araddr);
    end else begin
      rvalid = ($urandom_range(0, 3) == 0);
      rdata  = $urandom;
      rresp  = 2'($urandom);
    end
    #1;
    rsp_now = busy && (b_done || r_done);
    exp_v = {busy && cur_write && aw_cnt == 0, busy && cur_write && w_cnt == 0,
             busy && cur_write && aw_cnt == 1 && w_cnt == 1 && !b_done,
             busy && !cur_write && ar_cnt == 0, busy && !cur_write && ar_cnt == 1 && !r_done,
             rsp_now && !cur_owner, rsp_now && cur_owner};
    act_v = {awvalid, wvalid, bready, arvalid, rready, rsp0_valid, rsp1_valid};
    chk("axi_ctrl{aw,w,b,ar,r,rsp0,rsp1}", 64'(act_v), 64'(exp_v));
    if (awvalid && awready) begin chk("aw_addr", 64'(awaddr), 64'(cur_addr)); aw_cnt++; slv_awaddr = awaddr; end
    if (wvalid && wready)   begin chk("w_data", 64'(wdata), 64'(cur_wdata)); w_cnt++; slv_wdata = wdata; end
    if (bvalid && bready)   begin b_done = 1'b1; slv_mem[slv_awaddr] = slv_wdata; end
    if (arvalid) ar_hi++;
    if (arvalid && arready) begin chk("ar_addr", 64'(araddr), 64'(cur_addr)); ar_cnt++; slv_araddr = araddr; end
    if (rvalid && rready)   r_done = 1'b1;
    want = {req1_valid, req0_valid};
    rdy  = {req1_ready, req0_ready};
    if (busy) chk("ready_while_busy", 64'(rdy), 64'd0);
    else begin
      w = (want == 2'b11) ? !last : want[1];
      exp_r = (want == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
      chk("grant", 64'(rdy), 64'(exp_r));
      if (want != 2'b00) begin
        last = w; busy = 1'b1; cur_owner = w;
        cur_write = pend_w[w]; cur_addr = pend_a[w]; cur_wdata = pend_d[w];
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_done = 0; r_done = 0; ar_hi = 0;
        if (cur_write) begin
          ref_mem[cur_addr] = cur_wdata;
          e = '{rdata: 32'd0, resp: resp_of(cur_addr)};
        end else e = '{rdata: ref_rd(cur_addr), resp: resp_of(cur_addr)};
        if (w) exp_q1.push_back(e); else exp_q0.push_back(e);
        pend_v[w] = 1'b0;
        n_txn[w]++;
      end
    end
    if (rsp_now) busy = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((busy || pend_v[0] || pend_v[1]) && c < maxc) begin step(); c++; end
    chk("drain_timeout", 64'(busy || pend_v[0] || pend_v[1]), 64'd0);
    step();
  endtask

  task automatic issue(input int n, input bit wr, input logic [31:0] a, input logic [31:0] d);
    pend_v[n] = 1'b1; pend_w[n] = wr; pend_a[n] = a; pend_d[n] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_resp, rsp1_resp,
                             awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk({tag, "_addr"}, {awaddr, araddr}, 64'd0);
    chk({tag, "_data"}, {rsp0_rdata, rsp1_rdata}, 64'd0);
  endtask

  // Response monitor: every pulse must match the head of its client's queue.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk_axi); #2;
      if (rsp0_valid) begin
        if (exp_q0.size() == 0) chk("rsp0_unexpected", 64'd1, 64'd0);
        else begin e = exp_q0.pop_front(); chk("rsp0_payload", 64'({rsp0_rdata, rsp0_resp}), 64'(e)); end
      end
      if (rsp1_valid) begin
        if (exp_q1.size() == 0) chk("rsp1_unexpected", 64'd1, 64'd0);
        else begin e = exp_q1.pop_front(); chk("rsp1_payload", 64'({rsp1_rdata, rsp1_resp}), 64'(e)); end
      end
    end
  end

  initial begin
    int c;
    {req0_valid, req0_write, req0_addr, req0_wdata} = '0;
    {req1_valid, req1_write, req1_addr, req1_wdata} = '0;
    {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp} = '0;
    last = 1'b1; rdy_all = 1'b1;
    ref_mem[32'h44] = 32'h1234_5678;
    slv_mem[32'h44] = 32'h1234_5678;

    // reset state and constant attributes
    repeat (2) @(negedge clk_axi);
    #1;
    chk_quiet("reset");
    chk("w_const", 64'({w_id, w_len, w_size, w_burst, w_lock, w_cache, w_qos, w_region, w_user, w_prot, wstrb, wlast}),
        64'({6'd0, 8'd0, 3'b010, 2'b01, 1'b0, 12'd0, 1'b0, 3'd0, 4'hF, 1'b1}));
    chk("r_const", 64'({r_id, r_len, r_size, r_burst, r_lock, r_cache, r_qos, r_region, r_user, r_prot}),
        64'({6'd0, 8'd0, 3'b010, 2'b01, 1'b0, 12'd0, 1'b0, 3'd0}));
    reset_axi_n = 1'b1;

    // single write from client 0, slave always ready
    issue(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    drain(20);
    // single read from client 1 with ARREADY held off for the first cycles
    ar_wait = 4;
    issue(1, 1'b0, 32'h44, 32'h0);
    drain(20);
    chk("arvalid_hold_cycles", 64'(ar_hi), 64'd4);
    // error responses
    issue(1, 1'b1, 32'h200, 32'hA5A5_0001);
    drain(20);
    issue(0, 1'b0, 32'h304, 32'h0);
    drain(20);
    // both clients requesting back to back
    gen_en = 1'b1; req_always = 1'b1;
    n_txn[0] = 0; n_txn[1] = 0; c = 0;
    while ((n_txn[0] < 4 || n_txn[1] < 4) && c < 200) begin step(); c++; end
    chk("alternate_timeout", 64'(n_txn[0] >= 4 && n_txn[1] >= 4), 64'd1);
    gen_en = 1'b0; req_always = 1'b0;
    drain(50);
    // randomized traffic with a random slave
    gen_en = 1'b1; rdy_all = 1'b0;
    repeat (3000) step();
    gen_en = 1'b0;
    drain(200);

    // reset while waiting for read data
    rdy_all = 1'b1; hold_r = 1'b1;
    issue(1, 1'b0, 32'h48, 32'h0);
    c = 0;
    do begin step(); c++; end while (!rready && c < 20);
    chk("reach_rd_data", 64'(rready), 64'd1);
    reset_axi_n = 1'b0;
    #1;
    chk_quiet("mid_reset");
    busy = 1'b0; last = 1'b1; hold_r = 1'b0;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_done = 0; r_done = 0;
    exp_q0.delete(); exp_q1.delete();
    repeat (3) step();
    reset_axi_n = 1'b1;
    issue(0, 1'b1, 32'h104, 32'h0BAD_F00D);
    issue(1, 1'b0, 32'h104, 32'h0);
    step();
    chk("post_reset_tie_owner", 64'(cur_owner), 64'd0);
    drain(40);

    chk("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
